inst_encoder: RTL and testbench
===============================

Name: inst_encoder

Overview:
- Inverse of the immediate decode path: packs opcode, register fields, funct fields and a 32-bit immediate into a 32-bit RV32 instruction word.
- Tags each word with an instruction-memory byte address and streams it out with a valid/ready handshake.
- Used by the test/boot loader to fill instruction memory.
- Covers I-type (ALU-immediate), S-type, B-type and U-type (LUI); range-checks the immediate and reports errors.

Parameters:
- ADDR_W, 32, width of address counter and out_addr.
- BASE_ADDR, 32'h0000_0000, counter reset value.
- ERR_CNT_W, 8, width of saturating error counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- opcode  in  7  instruction opcode
- funct3  in  3  funct3 field
- funct7  in  7  funct7 field (used only by I-type shifts)
- rd  in  5  destination register
- rs1  in  5  source register 1
- rs2  in  5  source register 2
- imm  in  32  immediate as the decoder would return it
- out_valid  out  1  encoded word valid
- out_ready  in  1  downstream accepts
- out_data  out  32  encoded instruction
- out_addr  out  ADDR_W  byte address of out_data
- addr_load  in  1  load address counter
- addr_load_val  in  ADDR_W  value to load
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  01 range, 10 alignment, 11 illegal opcode
- err_cnt  out  ERR_CNT_W  saturating error count

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_addr=BASE_ADDR.
  - err_valid=0, err_code=0, err_cnt=0, counter=BASE_ADDR.
  - Mid-operation reset discards any held word.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; one-stage pipeline, full throughput).
  - Accept: encode in the same cycle; register out_data/out_addr on the next edge. Latency is 1 cycle.
  - out_data and out_addr stay stable while out_valid && !out_ready.
- Encoding (inst[6:0]=opcode; unused fields zero):
  - 0010011 I-type, inst = {imm12, rs1, funct3, rd, opcode}:
    - funct3 001/101 (shifts): imm12 = {funct7, imm[4:0]}; imm must be 0..31, else range error.
    - funct3 011 (SLTIU): imm must be 0..4095 (zero-extended); imm12 = imm[11:0].
    - Other funct3: imm must be -2048..2047 (signed); imm12 = imm[11:0].
  - 0100011 S-type: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; imm -2048..2047.
  - 1100011 B-type: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
    - imm[0]!=0 gives alignment error; checked before range.
    - Range -4096..4094.
  - 0110111 U-type: {imm[31:12], rd, opcode}; imm[11:0]!=0 gives alignment error.
  - Any other opcode: illegal error.
- Address counter:
  - Each accepted, error-free request takes the current counter as out_addr; counter += 4, wrapping modulo 2^ADDR_W.
  - Errored requests are accepted (in_ready rule unchanged) but produce no output word and do not advance the counter.
  - addr_load in the same cycle as an accept: the accepted word gets the old counter value; counter becomes addr_load_val with no increment. Load wins.
- Errors:
  - err_valid asserts the cycle after the accept; err_code is held until the next error.
  - err_cnt increments per error and saturates at all-ones.
- out_valid falls after the out_ready handshake unless a new valid word is accepted in the same cycle.

Optional Feature:
- Macro: INST_ENC_JTYPE_EN.
- Defined: opcode 1101111 (JAL) encodes {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - imm[0]!=0 gives alignment error.
  - Range -1048576..1048574, else range error.
- Not defined: 1101111 is illegal (err_code 11). No J-type logic synthesised.

Test Plan:
- After reset, ADDI opcode=0010011 funct3=000 rd=1 rs1=0 imm=32'hFFFFFFFF -> out_data=32'hFFF00093, out_addr=0x0, one cycle latency.
- SW opcode=0100011 funct3=010 rs1=1 rs2=2 imm=8, then BEQ opcode=1100011 funct3=000 rs1=1 rs2=2 imm=-4 back-to-back -> 32'h0020A423 @0x0, 32'hFE208EE3 @0x4, no bubble.
- LUI rd=5 imm=32'h12345000 -> 32'h123452B7; with imm=32'h12345001 -> err_code=10, no out_valid, counter unchanged, err_cnt+1.
- ADDI imm=2048 -> err_code=01; SLTIU imm=4095 -> 32'hFFF03013 (rd=0 rs1=0); opcode=1111111 -> err_code=11 (also 1101111 without INST_ENC_JTYPE_EN).
- out_ready=0 for 3 cycles with in_valid held -> in_ready=0, out_data stable; addr_load=1 val=0x100 with an accept -> that word @old address, next @0x100.
- rst_n low while out_valid=1 -> out_valid drops immediately, counter=BASE_ADDR, err_cnt=0.

Source files
------------

// File: rtl/inst_encoder.sv
// RV32 instruction encoder: packs fields + immediate into a word, tags it
// with an imem byte address. Optional JAL support: INST_ENC_JTYPE_EN.
module inst_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic [4:0]           rd,
  input  logic [4:0]           rs1,
  input  logic [4:0]           rs2,
  input  logic [31:0]          imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data,
  output logic [ADDR_W-1:0]    out_addr,
  input  logic                 addr_load,
  input  logic [ADDR_W-1:0]    addr_load_val,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
`ifdef INST_ENC_JTYPE_EN
  localparam logic [6:0] OP_JAL = 7'b1101111;
`endif

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_ALIGN = 2'b10;
  localparam logic [1:0] E_ILL   = 2'b11;

  logic [ADDR_W-1:0] r_cnt;
  logic [31:0]       w_word;
  logic [1:0]        w_err;
  logic              w_acc;
  logic              w_ok;
  logic              w_s12;
  logic              w_s13;
`ifdef INST_ENC_JTYPE_EN
  logic              w_s21;
`endif

  assign in_ready = !out_valid || out_ready;
  assign w_acc    = in_valid && in_ready;
  assign w_ok     = w_acc && (w_err == E_NONE);

  // sign-extension checks: upper bits must all equal the field's sign bit
  assign w_s12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign w_s13 = (imm[31:12] == '0) || (imm[31:12] == '1);
`ifdef INST_ENC_JTYPE_EN
  assign w_s21 = (imm[31:20] == '0) || (imm[31:20] == '1);
`endif

  // encode the request and classify any error
  always_comb begin
    w_word = '0;
    w_err  = E_NONE;
    unique case (opcode)
      OP_IMM: begin
        w_word = {imm[11:0], rs1, funct3, rd, opcode};
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          w_word[31:20] = {funct7, imm[4:0]};
          if (imm[31:5] != '0) w_err = E_RANGE;
        end else if (funct3 == 3'b011) begin
          if (imm[31:12] != '0) w_err = E_RANGE;
        end else if (!w_s12) begin
          w_err = E_RANGE;
        end
      end
      OP_ST: begin
        w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!w_s12) w_err = E_RANGE;
      end
      OP_BR: begin
        w_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                  imm[4:1], imm[11], opcode};
        if (imm[0])      w_err = E_ALIGN;
        else if (!w_s13) w_err = E_RANGE;
      end
      OP_LUI: begin
        w_word = {imm[31:12], rd, opcode};
        if (imm[11:0] != '0) w_err = E_ALIGN;
      end
`ifdef INST_ENC_JTYPE_EN
      OP_JAL: begin
        w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])      w_err = E_ALIGN;
        else if (!w_s21) w_err = E_RANGE;
      end
`endif
      default: w_err = E_ILL;
    endcase
  end

  // output stage: capture good words, drop valid after a consumed handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= BASE_ADDR;
    end else if (w_ok) begin
      out_valid <= 1'b1;
      out_data  <= w_word;
      out_addr  <= r_cnt;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // address counter: load wins over the post-accept increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= BASE_ADDR;
    end else if (addr_load) begin
      r_cnt <= addr_load_val;
    end else if (w_ok) begin
      r_cnt <= r_cnt + ADDR_W'(4);
    end
  end

  // error pulse, sticky code and saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_code  <= E_NONE;
      err_cnt   <= '0;
    end else begin
      err_valid <= w_acc && (w_err != E_NONE);
      if (w_acc && (w_err != E_NONE)) begin
        err_code <= w_err;
        if (~&err_cnt) err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder.
// Expected words are hand-encoded constants.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;
  logic        addr_load;
  logic [31:0] addr_load_val;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [7:0]  err_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int e_cnt = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr),
    .addr_load(addr_load), .addr_load_val(addr_load_val),
    .err_valid(err_valid), .err_code(err_code), .err_cnt(err_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2,
                     input logic [31:0] im);
    opcode = op; funct3 = f3; funct7 = f7;
    rd = d; rs1 = s1; rs2 = s2; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic good(input string tag, input logic [31:0] w,
                      input logic [31:0] a);
    tick();
    in_valid = 1'b0;
    check({tag, ".v"}, 32'(out_valid), 32'd1);
    check({tag, ".d"}, out_data, w);
    check({tag, ".a"}, out_addr, a);
    check({tag, ".ev"}, 32'(err_valid), 32'd0);
  endtask

  task automatic bad(input string tag, input logic [1:0] code);
    tick();
    in_valid = 1'b0;
    e_cnt++;
    check({tag, ".v"}, 32'(out_valid), 32'd0);
    check({tag, ".ev"}, 32'(err_valid), 32'd1);
    check({tag, ".ec"}, 32'(err_code), 32'(code));
    check({tag, ".cnt"}, 32'(err_cnt), 32'(e_cnt));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    addr_load = 1'b0; addr_load_val = '0;
    put(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    in_valid = 1'b0;
    #12;
    check("rst.v", 32'(out_valid), 32'd0);
    check("rst.d", out_data, 32'd0);
    check("rst.a", out_addr, 32'd0);
    check("rst.cnt", 32'(err_cnt), 32'd0);
    check("rst.ec", 32'(err_code), 32'd0);
    check("rst.rdy", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI x1,x0,-1; nothing visible until the edge
    put(7'h13, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF);
    #1;
    check("addi.lat", 32'(out_valid), 32'd0);
    good("addi", 32'hFFF0_0093, 32'h0);
    tick();
    check("idle.v", 32'(out_valid), 32'd0);

    // reload counter to 0 with no accept
    addr_load = 1'b1; addr_load_val = 32'h0;
    tick();
    addr_load = 1'b0;

    // SW then BEQ back to back
    put(7'h23, 3'b010, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    tick();
    check("sw.d", out_data, 32'h0020_A423);
    check("sw.a", out_addr, 32'h0);
    check("sw.rdy", 32'(in_ready), 32'd1);
    put(7'h63, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC);
    good("beq", 32'hFE20_8EE3, 32'h4);

    put(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000);
    good("lui", 32'h1234_52B7, 32'h8);
    put(7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5001);
    bad("lui.al", 2'b10);
    tick();
    check("ev.pulse", 32'(err_valid), 32'd0);
    check("ec.hold", 32'(err_code), 32'd2);

    put(7'h13, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    bad("addi.rng", 2'b01);
    put(7'h13, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_F800);
    good("addi.min", 32'h8000_0013, 32'hC);
    put(7'h13, 3'b011, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4095);
    good("sltiu", 32'hFFF0_3013, 32'h10);
    put(7'h13, 3'b011, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096);
    bad("sltiu.rng", 2'b01);
    put(7'h13, 3'b001, 7'd0, 5'd2, 5'd3, 5'd0, 32'd31);
    good("slli", 32'h01F1_9113, 32'h14);
    put(7'h13, 3'b101, 7'h20, 5'd2, 5'd3, 5'd0, 32'd32);
    bad("srai.rng", 2'b01);
    put(7'h63, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3);
    bad("beq.al", 2'b10);
    put(7'h63, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2, 32'd4096);
    bad("beq.rng", 2'b01);
    put(7'h7F, 3'b000, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    bad("ill", 2'b11);

    // backpressure with in_valid held
    out_ready = 1'b0;
    put(7'h13, 3'b000, 7'd0, 5'd1, 5'd1, 5'd0, 32'd1);
    tick();
    check("bp.v", 32'(out_valid), 32'd1);
    check("bp.d0", out_data, 32'h0010_8093);
    put(7'h13, 3'b000, 7'd0, 5'd1, 5'd1, 5'd0, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.rdy", 32'(in_ready), 32'd0);
      check("bp.d", out_data, 32'h0010_8093);
      check("bp.a", out_addr, 32'h18);
    end
    out_ready = 1'b1;
    #1;
    check("bp.rdy1", 32'(in_ready), 32'd1);
    good("bp.b", 32'h0020_8093, 32'h1C);

    // load in the same cycle as an accept
    put(7'h13, 3'b000, 7'd0, 5'd1, 5'd1, 5'd0, 32'd3);
    addr_load = 1'b1; addr_load_val = 32'h100;
    good("ld.old", 32'h0030_8093, 32'h20);
    addr_load = 1'b0;
    put(7'h13, 3'b000, 7'd0, 5'd1, 5'd1, 5'd0, 32'd4);
    good("ld.new", 32'h0040_8093, 32'h100);

    // JAL x1,+8
    put(7'h6F, 3'b000, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8);
`ifdef INST_ENC_JTYPE_EN
    good("jal", 32'h0080_00EF, 32'h104);
`else
    bad("jal.ill", 2'b11);
`endif

    // reset while a word is held
    out_ready = 1'b0;
    put(7'h13, 3'b000, 7'd0, 5'd1, 5'd1, 5'd0, 32'd5);
    tick();
    in_valid = 1'b0;
    check("mr.pre", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mr.v", 32'(out_valid), 32'd0);
    check("mr.a", out_addr, 32'h0);
    check("mr.cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    put(7'h13, 3'b000, 7'd0, 5'd1, 5'd1, 5'd0, 32'd6);
    good("mr.post", 32'h0060_8093, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
